// File: rtl/mod3_pkg.sv
// Shared types and constants for the serial divisibility-by-3 checker.
package mod3_pkg;

    // Frame-level FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Running remainder mod 3; the encoding 2'd3 is never produced
    typedef logic [1:0] rem_t;

    localparam rem_t REM_ZERO = 2'd0;

endpackage

// File: rtl/mod3_step.sv
// One MSB-first step of the mod-3 recurrence: r_next = (2*r + b) mod 3.
module mod3_step
    import mod3_pkg::*;
(
    input  rem_t rem_i,
    input  logic bit_i,
    output rem_t rem_o
);

    // Six-entry lookup; the unreachable remainder 3 folds back to zero
    always_comb begin
        rem_o = REM_ZERO;
        case ({rem_i, bit_i})
            3'b00_0: rem_o = 2'd0;
            3'b00_1: rem_o = 2'd1;
            3'b01_0: rem_o = 2'd2;
            3'b01_1: rem_o = 2'd0;
            3'b10_0: rem_o = 2'd1;
            3'b10_1: rem_o = 2'd2;
            default: rem_o = REM_ZERO;
        endcase
    end

endmodule

// File: rtl/mod3_counter.sv
// Framed serial divisibility-by-3 checker (MSB first).
// Optional build macro MOD3_PROTO_ERR_EN adds a sticky proto_err output.
module mod3_counter
    import mod3_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             data,
    output logic             result,
    output logic [1:0]       remainder,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count
`ifdef MOD3_PROTO_ERR_EN
    ,
    output logic             proto_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    rem_t             rem_q, rem_d;
    rem_t             rem_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Remainder after folding in the current bit
    mod3_step u_step (
        .rem_i (rem_q),
        .bit_i (data),
        .rem_o (rem_step)
    );

    // Next-state and output-register logic; start always opens a fresh frame
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (start) begin
            // The start bit is the MSB, so the remainder is simply that bit
            rem_d    = {1'b0, data};
            cnt_d    = CNT_W'(1);
            result_d = stop ? (data == 1'b0) : 1'b0;
            state_d  = stop ? DONE : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    rem_d = rem_step;
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    if (stop) begin
                        result_d = (rem_step == REM_ZERO);
                        state_d  = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        done_d = (state_d == DONE);
        busy_d = (state_d == RUN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= REM_ZERO;
            cnt_q    <= '0;
            result_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign result    = result_q;
    assign remainder = rem_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign bit_count = cnt_q;

`ifdef MOD3_PROTO_ERR_EN
    logic perr_q, perr_d;

    // Sticky protocol flag: cleared by a clean start, set by misuse or count overflow
    always_comb begin
        perr_d = perr_q;
        if (start && state_q != RUN) begin
            perr_d = 1'b0;
        end else if (start) begin
            perr_d = 1'b1;
        end else if (state_q == IDLE && stop) begin
            perr_d = 1'b1;
        end else if (state_q == RUN && cnt_q == CNT_MAX) begin
            perr_d = 1'b1;
        end
    end

    // Protocol flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign proto_err = perr_q;
`endif

endmodule

// File: tb/tb_mod3_counter.sv
// Bench for mod3_counter: fixed vector table, hand-written corner sequences
// and random frames checked against an arithmetic frame-value model.
module tb_mod3_counter;

    localparam int TB_CNT_W = 5;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start, stop, data;
    logic                result, done, busy;
    logic [1:0]          remainder;
    logic [TB_CNT_W-1:0] bit_count;
`ifdef MOD3_PROTO_ERR_EN
    logic                proto_err;
`endif

    int checks = 0;
    int errors = 0;

    mod3_counter #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .data      (data),
        .result    (result),
        .remainder (remainder),
        .done      (done),
        .busy      (busy),
        .bit_count (bit_count)
`ifdef MOD3_PROTO_ERR_EN
        ,
        .proto_err (proto_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bits;   // bits[len-1] is the first (MSB) bit
        int          len;
        logic [1:0]  rem;
        logic        res;
        int          cnt;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic d);
        @(negedge clk);
        start = s;
        stop  = p;
        data  = d;
    endtask

    // Idle cycles: no inputs, no done pulse expected
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("idle_done", done, 1'b0);
        end
    endtask

    // Drive one frame; returns positioned at the negedge after the stop edge.
    // chain=1 drives the first bit immediately (DONE-state start).
    task automatic frame(input logic [63:0] bits, input int len, input bit chain);
        for (int i = len - 1; i >= 0; i--) begin
            if (!(chain && i == len - 1)) @(negedge clk);
            if (i != len - 1) begin
                chk("mid_busy", busy, 1'b1);
                chk("mid_done", done, 1'b0);
            end
            start = (i == len - 1);
            stop  = (i == 0);
            data  = bits[i];
        end
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        data  = 1'b0;
    endtask

    task automatic chk_frame(input string nm, input logic [1:0] rem, input logic res, input int cnt);
        $display("frame %s: rem=%0d result=%0d cnt=%0d done=%0d (exp rem=%0d result=%0d cnt=%0d)",
                 nm, remainder, result, bit_count, done, rem, res, cnt);
        chk({nm, "_rem"}, remainder, rem);
        chk({nm, "_result"}, result, res);
        chk({nm, "_cnt"}, bit_count, cnt);
        chk({nm, "_done"}, done, 1'b1);
        chk({nm, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        tv[0] = '{64'b100000, 6,  2'd2, 1'b0, 6};
        tv[1] = '{64'b11,     2,  2'd0, 1'b1, 2};
        tv[2] = '{64'b1001,   4,  2'd0, 1'b1, 4};
        tv[3] = '{64'b0,      1,  2'd0, 1'b1, 1};
        tv[4] = '{64'b1,      1,  2'd1, 1'b0, 1};
        tv[5] = '{64'b10110,  5,  2'd1, 1'b0, 5};
        tv[6] = '{64'b1101,   4,  2'd1, 1'b0, 4};
        tv[7] = '{64'h1_FFFF_FFFF, 33, 2'd1, 1'b0, CNT_MAX};
        tv[8] = '{64'b0011,   4,  2'd0, 1'b1, 4};

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        data  = 1'b0;
        #1;
        chk("rst_result", result, 1'b0);
        chk("rst_rem", remainder, 2'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", bit_count, 0);
`ifdef MOD3_PROTO_ERR_EN
        chk("rst_perr", proto_err, 1'b0);
`endif
        #6 rst_n = 1'b1;

        // Fixed vectors; entry 4 starts in the DONE cycle of entry 3
        for (int i = 0; i < 9; i++) begin
            if (i > 0 && i != 4) idle(1);
            frame(tv[i].bits, tv[i].len, i == 4);
            chk_frame($sformatf("vec%0d", i), tv[i].rem, tv[i].res, tv[i].cnt);
        end
        idle(1);

        // Restart mid-frame: 1,0 then start again with 1,1,0 + stop (value 6)
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rs_done0", done, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("rs_done1", done, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("rs_done2", done, 1'b0);
        chk("rs_cnt_mid", bit_count, 1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("rs_done3", done, 1'b0);
`ifdef MOD3_PROTO_ERR_EN
        chk("rs_perr", proto_err, 1'b1);
`endif
        cyc(1'b0, 1'b0, 1'b0);
        chk_frame("restart", 2'd0, 1'b1, 3);
        idle(2);

        // Stop while idle: ignored, outputs held
        frame(64'b1001, 4, 1'b0);
        chk_frame("pre_idle_stop", 2'd0, 1'b1, 4);
        idle(1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        $display("idle stop: done=%0d result=%0d rem=%0d cnt=%0d", done, result, remainder, bit_count);
        chk("istop_done", done, 1'b0);
        chk("istop_busy", busy, 1'b0);
        chk("istop_result", result, 1'b1);
        chk("istop_rem", remainder, 2'd0);
        chk("istop_cnt", bit_count, 4);
`ifdef MOD3_PROTO_ERR_EN
        chk("istop_perr", proto_err, 1'b1);
`endif
        idle(1);

        // Asynchronous reset in the middle of a frame
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
`ifdef MOD3_PROTO_ERR_EN
        chk("pre_rst_perr", proto_err, 1'b0);
`endif
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_cnt", bit_count, 2);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        data  = 1'b0;
        #1;
        $display("mid reset: busy=%0d cnt=%0d rem=%0d", busy, bit_count, remainder);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_cnt", bit_count, 0);
        chk("mrst_rem", remainder, 2'd0);
        chk("mrst_result", result, 1'b0);
        chk("mrst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random frames against the arithmetic value model
        for (int f = 0; f < 30; f++) begin
            logic [63:0] bits;
            longint unsigned v;
            int len;
            bit chain;
            len   = $urandom_range(1, 40);
            bits  = {$urandom, $urandom};
            chain = ($urandom_range(0, 3) == 0) && (f > 0);
            if (!chain) idle($urandom_range(1, 2));
            v = 0;
            for (int i = len - 1; i >= 0; i--) v = v * 2 + bits[i];
            frame(bits, len, chain);
            chk_frame($sformatf("rnd%0d", f), 2'(v % 3), (v % 3) == 0,
                      (len > CNT_MAX) ? CNT_MAX : len);
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
